// File: rtl/riscv_pkg.sv
// Shared core types: NOP constant, fetch fault codes
// and the instruction-memory LOAD/RUN state enum.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W simple dual-port RAM, one sync write port,
// one enable-gated sync read port; unreset so it maps to BRAM.
module instr_mem_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Run-time loadable instruction memory with 1-cycle fetch
// handshake, stall/flush, and misalign/range fault flags.
// Ports: clk/rst, ld_* load port, req_* fetch, rsp_* response.
module instr_fetch_mem
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 64,
  parameter int              PC_W     = 32,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR),
  parameter int              IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic [IDX_W:0]    ld_count,
  output logic              running,
  input  logic              req_valid,
  input  logic [PC_W-1:0]   req_pc,
  output logic              req_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [PC_W-1:0]   rsp_pc,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [1:0]        rsp_fault
);

  localparam logic [IDX_W:0]  DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [PC_W-1:0] DEPTH_P = PC_W'(DEPTH);

  state_e            state_q, state_d;
  logic [IDX_W:0]    ld_count_q, ld_count_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic [1:0]        rsp_fault_q, rsp_fault_d;
  // set when rsp_instr comes from the RAM read register
  logic              src_mem_q, src_mem_d;

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [1:0]        pc_fault;
  logic [DATA_W-1:0] ram_rdata;

  assign running   = (state_q == ST_RUN);
  assign req_ready = running & ~stall & ~flush;
  assign accept    = req_valid & req_ready;

  always_comb begin
    pc_fault = FAULT_NONE;
    if (req_pc[1:0] != 2'b00) begin
      pc_fault = FAULT_MISALIGN;
    end else if ({2'b00, req_pc[PC_W-1:2]} >= DEPTH_P) begin
      pc_fault = FAULT_RANGE;
    end
  end

  assign rd_en = accept & (pc_fault == FAULT_NONE);
  assign wr_en = ~running & ld_en
               & ({1'b0, ld_addr} < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    if (wr_en && ld_count_q != DEPTH_C) begin
      ld_count_d = ld_count_q + 1'b1;
    end
    if (state_q == ST_LOAD && ld_done) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_fault_d = rsp_fault_q;
    src_mem_d   = src_mem_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (!stall) begin
      rsp_valid_d = accept;
      if (accept) begin
        rsp_pc_d    = req_pc;
        rsp_fault_d = pc_fault;
        src_mem_d   = (pc_fault == FAULT_NONE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      ld_count_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_fault_q <= FAULT_NONE;
      src_mem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_count_q  <= ld_count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_fault_q <= rsp_fault_d;
      src_mem_q   <= src_mem_d;
    end
  end

  instr_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (req_pc[IDX_W+1:2]),
    .rdata (ram_rdata)
  );

  assign ld_count  = ld_count_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_instr = src_mem_q ? ram_rdata : NOP_WORD;

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Parametrised, synchronous-read instruction memory with a fetch request/response handshake for the pipelined RISC-V core, replacing the fixed 64-word combinational ROM.
- Accepts byte PCs; returns instruction and PC one cycle later.
- Supports stall and flush; flags misaligned and out-of-range PCs.
- Programmed at run time through a word-load port under a LOAD/RUN state machine, instead of hard-coded initial contents.

Parameters:
DEPTH, 64, number of 32-bit instruction words (any value ≥2, not necessarily a power of two)
PC_W, 32, request PC width in bits (byte address)
DATA_W, 32, instruction width
NOP_WORD, 32'h00000033, word returned on fault (add x0,x0,x0)
IDX_W, $clog2(DEPTH), derived word-index width; not overridden

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
ld_en  in  1  load-port write strobe
ld_addr  in  IDX_W  word index for load
ld_data  in  DATA_W  instruction word to load
ld_done  in  1  end-of-program pulse; LOAD->RUN
ld_count  out  IDX_W+1  number of accepted load writes since reset
running  out  1  high in RUN state
req_valid  in  1  fetch request
req_pc  in  PC_W  fetch byte address
req_ready  out  1  request accepted this cycle when req_valid&req_ready
stall  in  1  hold response, block new requests
flush  in  1  kill in-flight response
rsp_valid  out  1  response valid
rsp_pc  out  PC_W  PC of returned instruction
rsp_instr  out  DATA_W  instruction word
rsp_fault  out  2  00 ok, 01 misaligned, 10 out-of-range

Behaviour:
- Reset (async assert, sync release) drives these values:
  - state=LOAD, running=0, ld_count=0, rsp_valid=0.
  - rsp_pc=0, rsp_instr=NOP_WORD, rsp_fault=00.
- Reset does not clear the memory array; contents survive reset.
- Reset mid-fetch discards the in-flight response. Reset mid-load keeps words already written.
- States:
  - LOAD: req_ready=0.
    - ld_en with ld_addr<DEPTH writes ld_data at the next edge and increments ld_count (saturating at DEPTH).
    - ld_addr≥DEPTH is ignored and not counted.
    - ld_done moves to RUN at the next edge. ld_en in the same cycle as ld_done still writes.
  - RUN: ld_en and ld_done are ignored. Leaving RUN requires rst.
- req_ready = running & ~stall & ~flush (combinational).
- Fetch, accepted in cycle N: at edge N+1, rsp_valid=1, rsp_pc=req_pc, and rsp_instr/rsp_fault hold the decode of req_pc. Latency is exactly 1 cycle; throughput is one per cycle.
- PC decode:
  - word index = req_pc[IDX_W+1:2].
  - If req_pc[1:0]≠0: fault 01.
  - Else if req_pc[PC_W-1:2]≥DEPTH: fault 10.
  - Misaligned has priority over out-of-range.
  - Any fault returns instr=NOP_WORD and reads no memory.
- No request accepted in cycle N (running, no stall/flush): rsp_valid=0 at N+1. rsp_pc/rsp_instr hold their values.
- stall=1 (flush=0): all rsp_* registers hold their values, including rsp_valid.
- flush=1: rsp_valid=0 at next edge and any same-cycle request is dropped. Flush has priority over stall. The redirect target is requested in the following cycle.
- Write/read collision cannot occur, because load only happens in LOAD and fetch only in RUN.

Decomposition:
- Shared package (riscv_pkg):
  - NOP constant.
  - fault code constants FAULT_NONE/FAULT_MISALIGN/FAULT_RANGE.
  - state enum {ST_LOAD, ST_RUN}.
- Sub-module instr_mem_array:
  - DEPTH×DATA_W simple dual-port RAM with one synchronous write port and one synchronous read port (read-enable gated).
  - No reset, so it infers block RAM.
- The top level holds the FSM, PC decode, handshake and response registers.

Test Plan:
- Load 13-word program (word0=32'h00002083 lw x1,0(x0) … word12), ld_done → ld_count=13, running=1 next cycle. Back-to-back fetch of PC 0,4,8 → rsp_instr 32'h00002083, 32'h00402103, 32'h00802183 on consecutive cycles, each 1 cycle after request.
- In LOAD, req_valid=1 → req_ready=0, rsp_valid stays 0. In RUN, ld_en at addr 0 with 32'hFFFFFFFF → memory unchanged, fetch PC 0 still returns 32'h00002083.
- Fetch PC 0x6 → rsp_fault=01, instr=32'h00000033. Fetch PC 0x100 with DEPTH=64 → fault 10, NOP. Fetch PC 0x102 → fault 01.
- Fetch PC 8, then stall 3 cycles → rsp_pc=8 and rsp_valid=1 held, req_ready=0. Release → next request accepted.
- Fetch PC 0x10 then flush+stall with req PC 0x20 in the same cycle → rsp_valid=0 next cycle, 0x20 not returned. Request 0x20 next cycle → returned 1 cycle later.
- Assert rst mid-run with a fetch in flight → rsp_valid=0 immediately, state LOAD, ld_count=0. ld_done then fetch PC 4 → original word still returned.
